ntt_unswap: RTL and testbench

NTT_UNSWAP -- requirements
Module: ntt_unswap

---
 rtl/ntt_unswap.sv | 139 +++++++++++++
 tb/tb_ntt_unswap.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ntt_unswap.sv
// ntt_unswap: regroups ALU output pairs into bank writeback pairs.
//
// In transpose mode two consecutive accepted pairs (a0,b0),(a1,b1) leave as
// (a0,a1) then (b0,b1); in bypass mode each pair passes straight through.
// A stage-1 register plus LATENCY-1 further stages carry data and valid.
//
// Ports:
//   clk              clock, all state on rising edge
//   rst              synchronous active-high reset
//   i_valid          input pair valid
//   o_ready          input pair accepted when i_valid && o_ready
//   i_alu_inout_swap 1 = transpose, 0 = bypass (sampled only with no pair held)
//   i_flush          releases a half-collected pair as (h0,h1)
//   i_data0/i_data1  ALU upper/lower lane
//   o_valid          writeback pair valid
//   o_data0/o_data1  bank-0 / bank-1 writeback word
module ntt_unswap #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned LATENCY    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic                  i_alu_inout_swap,
  input  logic                  i_flush,
  input  logic [DATA_WIDTH-1:0] i_data0,
  input  logic [DATA_WIDTH-1:0] i_data1,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data0,
  output logic [DATA_WIDTH-1:0] o_data1
);

  typedef enum logic {StEven, StOdd} state_e;

  state_e                state_q, state_d;
  logic                  pend_q, pend_d;
  logic [DATA_WIDTH-1:0] h0_q, h0_d, h1_q, h1_d, tail_q, tail_d;

  logic                  accept;
  logic                  iss_v;
  logic [DATA_WIDTH-1:0] iss_d0, iss_d1;

  logic                  pv_q  [LATENCY];
  logic [DATA_WIDTH-1:0] pd0_q [LATENCY];
  logic [DATA_WIDTH-1:0] pd1_q [LATENCY];

  // The owed second transpose word occupies the output slot, so only a
  // bypass pair (which also needs the slot) has to be stalled.
  assign o_ready = ~(pend_q & ~i_alu_inout_swap);
  assign accept  = i_valid & o_ready;

  always_comb begin
    state_d = state_q;
    pend_d  = 1'b0;
    h0_d    = h0_q;
    h1_d    = h1_q;
    tail_d  = tail_q;
    iss_v   = 1'b0;
    iss_d0  = '0;
    iss_d1  = '0;

    // Pending is only ever set on the way back to StEven, so it never
    // competes with the StOdd issue below.
    if (pend_q) begin
      iss_v  = 1'b1;
      iss_d0 = h1_q;
      iss_d1 = tail_q;
    end

    case (state_q)
      StEven: begin
        if (accept) begin
          if (i_alu_inout_swap) begin
            h0_d    = i_data0;
            h1_d    = i_data1;
            state_d = StOdd;
          end else begin
            iss_v  = 1'b1;
            iss_d0 = i_data0;
            iss_d1 = i_data1;
          end
        end
      end
      StOdd: begin
        // Only transpose mode can reach StOdd, so the held mode is implicit
        // and the swap input is ignored here.
        if (accept) begin
          iss_v   = 1'b1;
          iss_d0  = h0_q;
          iss_d1  = i_data0;
          tail_d  = i_data1;
          pend_d  = 1'b1;
          state_d = StEven;
        end else if (i_flush) begin
          iss_v   = 1'b1;
          iss_d0  = h0_q;
          iss_d1  = h1_q;
          state_d = StEven;
        end
      end
      default: state_d = StEven;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StEven;
      pend_q  <= 1'b0;
      h0_q    <= '0;
      h1_q    <= '0;
      tail_q  <= '0;
      for (int i = 0; i < int'(LATENCY); i++) begin
        pv_q[i]  <= 1'b0;
        pd0_q[i] <= '0;
        pd1_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      h0_q     <= h0_d;
      h1_q     <= h1_d;
      tail_q   <= tail_d;
      pv_q[0]  <= iss_v;
      pd0_q[0] <= iss_d0;
      pd1_q[0] <= iss_d1;
      for (int i = 1; i < int'(LATENCY); i++) begin
        pv_q[i]  <= pv_q[i-1];
        pd0_q[i] <= pd0_q[i-1];
        pd1_q[i] <= pd1_q[i-1];
      end
    end
  end

  assign o_valid = pv_q[LATENCY-1];
  assign o_data0 = pd0_q[LATENCY-1];
  assign o_data1 = pd1_q[LATENCY-1];

endmodule

// File: tb/tb_ntt_unswap.sv
// Scoreboard bench for ntt_unswap: two instances (LATENCY 1 and 3) share one
// stimulus stream; a pairing model predicts each writeback word and the cycle
// it must appear, and per-instance monitors pop and compare.
module tb_ntt_unswap;
  localparam int W = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, i_valid, swap, flush;
  logic [W-1:0] d0, d1;
  logic         rdy1, v1, rdy3, v3;
  logic [W-1:0] a1, b1, a3, b3;

  ntt_unswap #(.DATA_WIDTH(W), .LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(rdy1),
    .i_alu_inout_swap(swap), .i_flush(flush), .i_data0(d0), .i_data1(d1),
    .o_valid(v1), .o_data0(a1), .o_data1(b1)
  );

  ntt_unswap #(.DATA_WIDTH(W), .LATENCY(3)) u_l3 (
    .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(rdy3),
    .i_alu_inout_swap(swap), .i_flush(flush), .i_data0(d0), .i_data1(d1),
    .o_valid(v3), .o_data0(a3), .o_data1(b3)
  );

  typedef struct {
    logic [W-1:0] x0;
    logic [W-1:0] x1;
    int           base;    // edge index at which the producing event happens
    int           second;  // 1 for the word that trails by one cycle
  } exp_t;

  exp_t q1[$];
  exp_t q3[$];
  exp_t e1, e3;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  bit mon_en = 1'b0;

  // Model: a transpose pair waiting for its partner, and whether the previous
  // edge completed a transpose group (its second word then occupies the slot).
  bit           held = 1'b0;
  bit           owed = 1'b0;
  logic [W-1:0] held_a, held_b;

  function automatic int due(exp_t e, int lat);
    return e.base + lat - 1 + e.second;
  endfunction

  task automatic push(logic [W-1:0] x0, logic [W-1:0] x1, int base, int second);
    exp_t e;
    e.x0 = x0; e.x1 = x1; e.base = base; e.second = second;
    q1.push_back(e);
    q3.push_back(e);
  endtask

  task automatic step(bit r, bit v, bit s, bit f, logic [W-1:0] x0, logic [W-1:0] x1);
    bit exp_rdy;
    bit acc;
    int e;
    @(posedge clk);
    #2;
    rst = r; i_valid = v; swap = s; flush = f; d0 = x0; d1 = x1;
    #1;
    exp_rdy = !(owed && !s);
    checks += 2;
    if (rdy1 !== exp_rdy) begin
      failures++;
      $display("FAIL ready_l1 cyc=%0d got=%b exp=%b", cyc, rdy1, exp_rdy);
    end
    if (rdy3 !== exp_rdy) begin
      failures++;
      $display("FAIL ready_l3 cyc=%0d got=%b exp=%b", cyc, rdy3, exp_rdy);
    end
    acc = v && exp_rdy;
    e = cyc + 1;
    if (r) begin
      held = 1'b0;
      owed = 1'b0;
      while (q1.size() > 0 && due(q1[$], 1) >= e) void'(q1.pop_back());
      while (q3.size() > 0 && due(q3[$], 3) >= e) void'(q3.pop_back());
    end else begin
      owed = 1'b0;
      if (held) begin
        if (acc) begin
          push(held_a, x0, e, 0);
          push(held_b, x1, e, 1);
          held = 1'b0;
          owed = 1'b1;
        end else if (f) begin
          push(held_a, held_b, e, 0);
          held = 1'b0;
        end
      end else if (acc) begin
        if (s) begin
          held = 1'b1; held_a = x0; held_b = x1;
        end else begin
          push(x0, x1, e, 0);
        end
      end
    end
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1, 1'b0, '0, '0);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (v1) begin
        checks++;
        if (q1.size() == 0) begin
          failures++;
          $display("FAIL out_l1 cyc=%0d got=(%h,%h) exp=none", cyc, a1, b1);
        end else begin
          e1 = q1.pop_front();
          if (a1 !== e1.x0 || b1 !== e1.x1 || cyc != due(e1, 1)) begin
            failures++;
            $display("FAIL out_l1 cyc=%0d got=(%h,%h) exp=(%h,%h)@%0d",
                     cyc, a1, b1, e1.x0, e1.x1, due(e1, 1));
          end
        end
      end else if (q1.size() > 0 && due(q1[0], 1) <= cyc) begin
        checks++;
        failures++;
        $display("FAIL missing_l1 cyc=%0d got=none exp=(%h,%h)", cyc, q1[0].x0, q1[0].x1);
        void'(q1.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      if (v3) begin
        checks++;
        if (q3.size() == 0) begin
          failures++;
          $display("FAIL out_l3 cyc=%0d got=(%h,%h) exp=none", cyc, a3, b3);
        end else begin
          e3 = q3.pop_front();
          if (a3 !== e3.x0 || b3 !== e3.x1 || cyc != due(e3, 3)) begin
            failures++;
            $display("FAIL out_l3 cyc=%0d got=(%h,%h) exp=(%h,%h)@%0d",
                     cyc, a3, b3, e3.x0, e3.x1, due(e3, 3));
          end
        end
      end else if (q3.size() > 0 && due(q3[0], 3) <= cyc) begin
        checks++;
        failures++;
        $display("FAIL missing_l3 cyc=%0d got=none exp=(%h,%h)", cyc, q3[0].x0, q3[0].x1);
        void'(q3.pop_front());
      end
    end
  end

  logic [W-1:0] ra [4];
  logic [W-1:0] rb [4];
  bit           mode;

  initial begin
    rst = 1'b1; i_valid = 1'b0; swap = 1'b0; flush = 1'b0; d0 = '0; d1 = '0;
    step(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    step(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    step(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    checks += 4;
    if (v1 !== 1'b0 || a1 !== '0 || b1 !== '0) begin
      failures++;
      $display("FAIL reset_out_l1 got=(%b,%h,%h) exp=(0,0,0)", v1, a1, b1);
    end
    if (v3 !== 1'b0 || a3 !== '0 || b3 !== '0) begin
      failures++;
      $display("FAIL reset_out_l3 got=(%b,%h,%h) exp=(0,0,0)", v3, a3, b3);
    end
    if (rdy1 !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready_l1 got=%b exp=1", rdy1);
    end
    if (rdy3 !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready_l3 got=%b exp=1", rdy3);
    end
    mon_en = 1'b1;

    // Bypass back-to-back.
    step(1'b0, 1'b1, 1'b0, 1'b0, 64'd1, 64'd2);
    step(1'b0, 1'b1, 1'b0, 1'b0, 64'd3, 64'd4);
    idle(5);

    // Continuous transpose stream.
    for (int i = 0; i < 4; i++) begin
      ra[i] = {$urandom, $urandom};
      rb[i] = {$urandom, $urandom};
    end
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1, 1'b0, ra[i], rb[i]);
    idle(5);

    // Bypass pair colliding with the owed second word, then retried.
    step(1'b0, 1'b1, 1'b1, 1'b0, 64'd5, 64'd6);
    step(1'b0, 1'b1, 1'b1, 1'b0, 64'd7, 64'd8);
    step(1'b0, 1'b1, 1'b0, 1'b0, 64'd9, 64'd10);
    step(1'b0, 1'b1, 1'b0, 1'b0, 64'd9, 64'd10);
    idle(5);

    // Flush of a half pair, then a fresh transpose group.
    step(1'b0, 1'b1, 1'b1, 1'b0, 64'd5, 64'd6);
    step(1'b0, 1'b0, 1'b1, 1'b1, '0, '0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 64'd11, 64'd12);
    step(1'b0, 1'b1, 1'b1, 1'b0, 64'd13, 64'd14);
    idle(5);

    // Reset discards a held half pair.
    step(1'b0, 1'b1, 1'b1, 1'b0, 64'd5, 64'd6);
    step(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 64'd1, 64'd2);
    idle(5);

    // Randomized traffic with mode runs, flushes and rare resets.
    mode = 1'b1;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 7) == 0) mode = ~mode;
      step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 80, mode,
           $urandom_range(0, 9) == 0, {$urandom, $urandom}, {$urandom, $urandom});
    end
    idle(10);

    checks += 2;
    if (q1.size() != 0) begin
      failures++;
      $display("FAIL drain_l1 got=%0d pending exp=0", q1.size());
    end
    if (q3.size() != 0) begin
      failures++;
      $display("FAIL drain_l3 got=%0d pending exp=0", q3.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
